// File: rtl/tl_serdes_pkg.sv
// Shared TileLink serdes definitions: channel ids, field widths and the merged-beat payload.
// Used by both the transmit-side arbiter and the receive-side beat router.
package tl_serdes_pkg;

    localparam int unsigned NUM_TL_CHAN = 5;
    localparam int unsigned CHAN_W      = 3;
    localparam int unsigned OPC_W       = 3;
    localparam int unsigned PARAM_W     = 3;
    localparam int unsigned SIZE_W      = 8;
    localparam int unsigned SRC_W       = 8;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned UNION_W     = 9;
    localparam int unsigned STAT_CNT_W  = 16;

    localparam logic [CHAN_W-1:0] CHAN_A = 3'd0;
    localparam logic [CHAN_W-1:0] CHAN_B = 3'd1;
    localparam logic [CHAN_W-1:0] CHAN_C = 3'd2;
    localparam logic [CHAN_W-1:0] CHAN_D = 3'd3;
    localparam logic [CHAN_W-1:0] CHAN_E = 3'd4;

    typedef struct packed {
        logic [CHAN_W-1:0]  chan_id;
        logic [OPC_W-1:0]   opcode;
        logic [PARAM_W-1:0] param;
        logic [SIZE_W-1:0]  size;
        logic [SRC_W-1:0]   source;
        logic [DATA_W-1:0]  address;
        logic [DATA_W-1:0]  data;
        logic               corrupt;
        logic [UNION_W-1:0] mask_sink;
        logic               last;
    } tl_merged_beat_t;

    function automatic logic chan_in_range(input logic [CHAN_W-1:0] chan);
        return chan < CHAN_W'(NUM_TL_CHAN);
    endfunction

endpackage

// File: rtl/tl_beat_router_stats.sv
// Saturating statistics counters for the beat router: completed messages per channel and dropped beats.
module tl_beat_router_stats
    import tl_serdes_pkg::*;
#(
    parameter int unsigned NUM_CHAN = NUM_TL_CHAN,
    parameter int unsigned CNT_W    = STAT_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      msg_done_i,
    input  logic [CHAN_W-1:0]         msg_chan_i,
    input  logic                      drop_i,
    output logic [NUM_CHAN*CNT_W-1:0] msg_cnt_o,
    output logic [CNT_W-1:0]          drop_cnt_o
);

    logic [CNT_W-1:0] msg_cnt_q [NUM_CHAN];
    logic [CNT_W-1:0] drop_cnt_q;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_msg_cnt
        always_ff @(posedge clock) begin
            if (reset) begin
                msg_cnt_q[i] <= '0;
            end else if (msg_done_i && (msg_chan_i == CHAN_W'(i)) && (msg_cnt_q[i] != '1)) begin
                msg_cnt_q[i] <= msg_cnt_q[i] + CNT_W'(1);
            end
        end
        assign msg_cnt_o[i*CNT_W +: CNT_W] = msg_cnt_q[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_i && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: rtl/tl_beat_router.sv
// Receive-side TileLink beat router: one stage register, per-channel one-hot valid, message lock.
// Optional statistics counters are enabled with `define TL_BEAT_ROUTER_STATS_EN.
module tl_beat_router
    import tl_serdes_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_in_valid,
    output logic                   io_in_ready,
    input  logic [CHAN_W-1:0]      io_in_bits_chanId,
    input  logic [OPC_W-1:0]       io_in_bits_opcode,
    input  logic [PARAM_W-1:0]     io_in_bits_param,
    input  logic [SIZE_W-1:0]      io_in_bits_size,
    input  logic [SRC_W-1:0]       io_in_bits_source,
    input  logic [DATA_W-1:0]      io_in_bits_address,
    input  logic [DATA_W-1:0]      io_in_bits_data,
    input  logic                   io_in_bits_corrupt,
    input  logic [UNION_W-1:0]     io_in_bits_union,
    input  logic                   io_in_bits_last,
    output logic [NUM_TL_CHAN-1:0] io_out_valid,
    input  logic [NUM_TL_CHAN-1:0] io_out_ready,
    output logic [CHAN_W-1:0]      io_out_bits_chanId,
    output logic [OPC_W-1:0]       io_out_bits_opcode,
    output logic [PARAM_W-1:0]     io_out_bits_param,
    output logic [SIZE_W-1:0]      io_out_bits_size,
    output logic [SRC_W-1:0]       io_out_bits_source,
    output logic [DATA_W-1:0]      io_out_bits_address,
    output logic [DATA_W-1:0]      io_out_bits_data,
    output logic                   io_out_bits_corrupt,
    output logic [UNION_W-1:0]     io_out_bits_union,
    output logic                   io_out_bits_last,
    output logic                   io_err_chan,
    output logic                   io_err_mismatch
`ifdef TL_BEAT_ROUTER_STATS_EN
    ,
    output logic [NUM_TL_CHAN*STAT_CNT_W-1:0] io_msg_cnt,
    output logic [STAT_CNT_W-1:0]             io_drop_cnt
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    tl_merged_beat_t   in_beat;
    tl_merged_beat_t   beat_q;
    logic              full_q;
    logic [0:0]        state_q, state_d;
    logic [CHAN_W-1:0] lock_chan_q, lock_chan_d;
    logic              err_chan_q, err_chan_d;
    logic              err_mm_q, err_mm_d;
    logic              out_fire, in_fire, bad_chan, mismatch, store, drop;

    assign in_beat = '{
        chan_id:   io_in_bits_chanId,
        opcode:    io_in_bits_opcode,
        param:     io_in_bits_param,
        size:      io_in_bits_size,
        source:    io_in_bits_source,
        address:   io_in_bits_address,
        data:      io_in_bits_data,
        corrupt:   io_in_bits_corrupt,
        mask_sink: io_in_bits_union,
        last:      io_in_bits_last
    };

    // Valid is decoded purely from stage state, so out_ready never reaches it.
    assign io_out_valid = full_q ? (NUM_TL_CHAN'(1) << beat_q.chan_id) : '0;
    assign out_fire     = |(io_out_valid & io_out_ready);
    assign io_in_ready  = ~full_q | out_fire;
    assign in_fire      = io_in_valid & io_in_ready;

    assign bad_chan = ~chan_in_range(in_beat.chan_id);
    assign mismatch = (state_q == LOCKED) && (in_beat.chan_id != lock_chan_q);
    assign store    = in_fire & ~bad_chan & ~mismatch;
    assign drop     = in_fire & (bad_chan | mismatch);

    // Lock FSM and sticky error flags; the lock moves only on stored beats.
    always_comb begin
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        err_chan_d  = err_chan_q | (in_fire & bad_chan);
        err_mm_d    = err_mm_q | (in_fire & ~bad_chan & mismatch);
        if (store) begin
            case (state_q)
                IDLE: begin
                    if (!in_beat.last) begin
                        state_d     = LOCKED;
                        lock_chan_d = in_beat.chan_id;
                    end
                end
                LOCKED: begin
                    if (in_beat.last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_chan_q <= '0;
            err_chan_q  <= 1'b0;
            err_mm_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
            err_chan_q  <= err_chan_d;
            err_mm_q    <= err_mm_d;
        end
    end

    // Stage register: a store reloads even while the old beat leaves.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_q <= 1'b0;
            beat_q <= '0;
        end else if (store) begin
            full_q <= 1'b1;
            beat_q <= in_beat;
        end else if (out_fire) begin
            full_q <= 1'b0;
        end
    end

    assign io_out_bits_chanId  = beat_q.chan_id;
    assign io_out_bits_opcode  = beat_q.opcode;
    assign io_out_bits_param   = beat_q.param;
    assign io_out_bits_size    = beat_q.size;
    assign io_out_bits_source  = beat_q.source;
    assign io_out_bits_address = beat_q.address;
    assign io_out_bits_data    = beat_q.data;
    assign io_out_bits_corrupt = beat_q.corrupt;
    assign io_out_bits_union   = beat_q.mask_sink;
    assign io_out_bits_last    = beat_q.last;
    assign io_err_chan         = err_chan_q;
    assign io_err_mismatch     = err_mm_q;

`ifdef TL_BEAT_ROUTER_STATS_EN
    tl_beat_router_stats #(
        .NUM_CHAN (NUM_TL_CHAN),
        .CNT_W    (STAT_CNT_W)
    ) u_stats (
        .clock      (clock),
        .reset      (reset),
        .msg_done_i (out_fire & beat_q.last),
        .msg_chan_i (beat_q.chan_id),
        .drop_i     (drop),
        .msg_cnt_o  (io_msg_cnt),
        .drop_cnt_o (io_drop_cnt)
    );
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_tl_beat_router.sv
// Directed, table-driven bench for tl_beat_router plus hand-written reset-mid-burst sequence.
module tb_tl_beat_router;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [2:0]  io_in_bits_chanId;
    logic [2:0]  io_in_bits_opcode;
    logic [2:0]  io_in_bits_param;
    logic [7:0]  io_in_bits_size;
    logic [7:0]  io_in_bits_source;
    logic [63:0] io_in_bits_address;
    logic [63:0] io_in_bits_data;
    logic        io_in_bits_corrupt;
    logic [8:0]  io_in_bits_union;
    logic        io_in_bits_last;
    logic [4:0]  io_out_valid;
    logic [4:0]  io_out_ready;
    logic [2:0]  io_out_bits_chanId;
    logic [2:0]  io_out_bits_opcode;
    logic [2:0]  io_out_bits_param;
    logic [7:0]  io_out_bits_size;
    logic [7:0]  io_out_bits_source;
    logic [63:0] io_out_bits_address;
    logic [63:0] io_out_bits_data;
    logic        io_out_bits_corrupt;
    logic [8:0]  io_out_bits_union;
    logic        io_out_bits_last;
    logic        io_err_chan;
    logic        io_err_mismatch;
`ifdef TL_BEAT_ROUTER_STATS_EN
    logic [79:0] io_msg_cnt;
    logic [15:0] io_drop_cnt;
`endif

    always #5 clock = ~clock;

    tl_beat_router dut (
        .clock               (clock),
        .reset               (reset),
        .io_in_valid         (io_in_valid),
        .io_in_ready         (io_in_ready),
        .io_in_bits_chanId   (io_in_bits_chanId),
        .io_in_bits_opcode   (io_in_bits_opcode),
        .io_in_bits_param    (io_in_bits_param),
        .io_in_bits_size     (io_in_bits_size),
        .io_in_bits_source   (io_in_bits_source),
        .io_in_bits_address  (io_in_bits_address),
        .io_in_bits_data     (io_in_bits_data),
        .io_in_bits_corrupt  (io_in_bits_corrupt),
        .io_in_bits_union    (io_in_bits_union),
        .io_in_bits_last     (io_in_bits_last),
        .io_out_valid        (io_out_valid),
        .io_out_ready        (io_out_ready),
        .io_out_bits_chanId  (io_out_bits_chanId),
        .io_out_bits_opcode  (io_out_bits_opcode),
        .io_out_bits_param   (io_out_bits_param),
        .io_out_bits_size    (io_out_bits_size),
        .io_out_bits_source  (io_out_bits_source),
        .io_out_bits_address (io_out_bits_address),
        .io_out_bits_data    (io_out_bits_data),
        .io_out_bits_corrupt (io_out_bits_corrupt),
        .io_out_bits_union   (io_out_bits_union),
        .io_out_bits_last    (io_out_bits_last),
        .io_err_chan         (io_err_chan),
        .io_err_mismatch     (io_err_mismatch)
`ifdef TL_BEAT_ROUTER_STATS_EN
        ,
        .io_msg_cnt          (io_msg_cnt),
        .io_drop_cnt         (io_drop_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic [2:0]  ch;
        logic        last;
        logic [63:0] d;
        logic [4:0]  ordy;
        logic        exp_irdy;
        logic [4:0]  exp_ov;
        logic [63:0] exp_d;
        logic        exp_last;
        logic        exp_ec;
        logic        exp_em;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic v, input logic [2:0] ch, input logic l,
                                input logic [63:0] d, input logic [4:0] r, input logic ei,
                                input logic [4:0] eov, input logic [63:0] ed, input logic el,
                                input logic ec, input logic em);
        vec_t t;
        t.v = v; t.ch = ch; t.last = l; t.d = d; t.ordy = r;
        t.exp_irdy = ei; t.exp_ov = eov; t.exp_d = ed; t.exp_last = el;
        t.exp_ec = ec; t.exp_em = em;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] ch, input logic l, input logic [63:0] d);
        io_in_valid        = v;
        io_in_bits_chanId  = ch;
        io_in_bits_last    = l;
        io_in_bits_data    = d;
        io_in_bits_address = ~d;
        io_in_bits_source  = d[7:0];
        io_in_bits_opcode  = 3'd4;
        io_in_bits_param   = 3'd1;
        io_in_bits_size    = 8'd3;
        io_in_bits_corrupt = 1'b0;
        io_in_bits_union   = 9'h0ff;
    endtask

    initial begin
        // Single D; A burst with stall; mismatch; bad chan; alternating B/E.
        vecs[0]  = mk(1, 3'd3, 1, 64'h11, 5'h1f, 1, 5'b00000, 64'h0,  0, 0, 0);
        vecs[1]  = mk(0, 3'd0, 0, 64'h0,  5'h1f, 1, 5'b01000, 64'h11, 1, 0, 0);
        vecs[2]  = mk(1, 3'd0, 0, 64'hA1, 5'h1f, 1, 5'b00000, 64'h0,  0, 0, 0);
        vecs[3]  = mk(1, 3'd0, 0, 64'hA2, 5'h1f, 1, 5'b00001, 64'hA1, 0, 0, 0);
        vecs[4]  = mk(1, 3'd0, 0, 64'hA3, 5'h1e, 0, 5'b00001, 64'hA2, 0, 0, 0);
        vecs[5]  = mk(1, 3'd0, 0, 64'hA3, 5'h1e, 0, 5'b00001, 64'hA2, 0, 0, 0);
        vecs[6]  = mk(1, 3'd0, 0, 64'hA3, 5'h1f, 1, 5'b00001, 64'hA2, 0, 0, 0);
        vecs[7]  = mk(1, 3'd0, 1, 64'hA4, 5'h1f, 1, 5'b00001, 64'hA3, 0, 0, 0);
        vecs[8]  = mk(0, 3'd0, 0, 64'h0,  5'h1f, 1, 5'b00001, 64'hA4, 1, 0, 0);
        vecs[9]  = mk(1, 3'd1, 1, 64'hB1, 5'h1f, 1, 5'b00000, 64'h0,  0, 0, 0);
        vecs[10] = mk(0, 3'd0, 0, 64'h0,  5'h1f, 1, 5'b00010, 64'hB1, 1, 0, 0);
        vecs[11] = mk(1, 3'd0, 0, 64'hA5, 5'h1f, 1, 5'b00000, 64'h0,  0, 0, 0);
        vecs[12] = mk(1, 3'd2, 0, 64'hC1, 5'h1f, 1, 5'b00001, 64'hA5, 0, 0, 0);
        vecs[13] = mk(1, 3'd0, 1, 64'hA6, 5'h1f, 1, 5'b00000, 64'h0,  0, 0, 1);
        vecs[14] = mk(0, 3'd0, 0, 64'h0,  5'h1f, 1, 5'b00001, 64'hA6, 1, 0, 1);
        vecs[15] = mk(1, 3'd1, 1, 64'hB2, 5'h1f, 1, 5'b00000, 64'h0,  0, 0, 1);
        vecs[16] = mk(0, 3'd0, 0, 64'h0,  5'h1f, 1, 5'b00010, 64'hB2, 1, 0, 1);
        vecs[17] = mk(1, 3'd6, 1, 64'h66, 5'h1f, 1, 5'b00000, 64'h0,  0, 0, 1);
        vecs[18] = mk(1, 3'd4, 1, 64'hE1, 5'h1f, 1, 5'b00000, 64'h0,  0, 1, 1);
        vecs[19] = mk(0, 3'd0, 0, 64'h0,  5'h1f, 1, 5'b10000, 64'hE1, 1, 1, 1);
        vecs[20] = mk(1, 3'd1, 1, 64'hB3, 5'h1f, 1, 5'b00000, 64'h0,  0, 1, 1);
        vecs[21] = mk(1, 3'd4, 1, 64'hE2, 5'h1f, 1, 5'b00010, 64'hB3, 1, 1, 1);
        vecs[22] = mk(1, 3'd1, 1, 64'hB4, 5'h1f, 1, 5'b10000, 64'hE2, 1, 1, 1);
        vecs[23] = mk(1, 3'd4, 1, 64'hE3, 5'h1f, 1, 5'b00010, 64'hB4, 1, 1, 1);
        vecs[24] = mk(0, 3'd0, 0, 64'h0,  5'h1f, 1, 5'b10000, 64'hE3, 1, 1, 1);
        vecs[25] = mk(0, 3'd0, 0, 64'h0,  5'h1f, 1, 5'b00000, 64'h0,  0, 1, 1);

        reset        = 1'b1;
        io_out_ready = 5'h1f;
        drive(0, 3'd0, 0, 64'h0);
        repeat (3) @(negedge clock);
        chk("rst_ov",    64'(io_out_valid),        64'h0);
        chk("rst_data",  io_out_bits_data,         64'h0);
        chk("rst_addr",  io_out_bits_address,      64'h0);
        chk("rst_ec",    64'(io_err_chan),         64'h0);
        chk("rst_em",    64'(io_err_mismatch),     64'h0);
        chk("rst_irdy",  64'(io_in_ready),         64'h1);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            drive(vecs[i].v, vecs[i].ch, vecs[i].last, vecs[i].d);
            io_out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_irdy", i), 64'(io_in_ready),     64'(vecs[i].exp_irdy));
            chk($sformatf("v%0d_ov", i),   64'(io_out_valid),    64'(vecs[i].exp_ov));
            chk($sformatf("v%0d_ec", i),   64'(io_err_chan),     64'(vecs[i].exp_ec));
            chk($sformatf("v%0d_em", i),   64'(io_err_mismatch), 64'(vecs[i].exp_em));
            if (vecs[i].exp_ov != 5'b0) begin
                chk($sformatf("v%0d_data", i), io_out_bits_data,        vecs[i].exp_d);
                chk($sformatf("v%0d_addr", i), io_out_bits_address,     ~vecs[i].exp_d);
                chk($sformatf("v%0d_src", i),  64'(io_out_bits_source), 64'(vecs[i].exp_d[7:0]));
                chk($sformatf("v%0d_last", i), 64'(io_out_bits_last),   64'(vecs[i].exp_last));
            end
        end

        // Reset lands on beat 2 of an A burst, then a fresh single-beat C message.
        @(negedge clock);
        drive(1, 3'd0, 0, 64'hD1);
        @(negedge clock);
        drive(1, 3'd0, 0, 64'hD2);
        reset = 1'b1;
        #1;
        chk("mr_pre_ov", 64'(io_out_valid), 64'h1);
        @(negedge clock);
        drive(0, 3'd0, 0, 64'h0);
        chk("mr_ov",   64'(io_out_valid),    64'h0);
        chk("mr_data", io_out_bits_data,     64'h0);
        chk("mr_ec",   64'(io_err_chan),     64'h0);
        chk("mr_em",   64'(io_err_mismatch), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(1, 3'd2, 1, 64'hC7);
        #1;
        chk("mr_c_pre", 64'(io_out_valid), 64'h0);
        @(negedge clock);
        drive(0, 3'd0, 0, 64'h0);
        #1;
        chk("mr_c_ov",   64'(io_out_valid),    64'h04);
        chk("mr_c_data", io_out_bits_data,     64'hC7);
        chk("mr_c_em",   64'(io_err_mismatch), 64'h0);
        @(negedge clock);
        chk("mr_c_done", 64'(io_out_valid), 64'h0);
`ifdef TL_BEAT_ROUTER_STATS_EN
        chk("st_msg_c",  64'(io_msg_cnt[47:32]), 64'h1);
        chk("st_msg_a",  64'(io_msg_cnt[15:0]),  64'h0);
        chk("st_drop",   64'(io_drop_cnt),       64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
